// File: rtl/divisor_pkg.sv
// Shared types for the divider issue stage: operand pair layout and counter width.
package divisor_pkg;

    localparam int unsigned OP_W     = 32;
    localparam int unsigned DZ_CNT_W = 8;

    typedef logic [OP_W-1:0] operand_t;

    typedef struct packed {
        operand_t num;
        operand_t den;
    } op_pair_t;

endpackage

// File: rtl/divisor_fifo.sv
// Synchronous FIFO of operand pairs. The head is read straight from registered storage.
module divisor_fifo
    import divisor_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push_i,
    input  op_pair_t wdata_i,
    input  logic     pop_i,
    output op_pair_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    // The extra MSB tells a full FIFO from an empty one when the indices match.
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    op_pair_t    mem_q [DEPTH];
    logic        do_push, do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/divisor_operand_queue.sv
// Issue stage for the pipelined divider: buffers operand pairs, drops zero denominators
// and limits in-flight divisions with a credit counter.
module divisor_operand_queue
    import divisor_pkg::*;
#(
    parameter int unsigned SIZE         = 32,  // must not exceed OP_W
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned MAX_INFLIGHT = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [SIZE-1:0]                     in_num,
    input  logic [SIZE-1:0]                     in_den,
    output logic                                div_start,
    output logic [SIZE-1:0]                     div_num,
    output logic [SIZE-1:0]                     div_den,
    input  logic                                res_taken,
    output logic                                dz_pulse,
    output logic [DZ_CNT_W-1:0]                 dz_count,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight
);

    localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);

    op_pair_t            wr_pair, head;
    logic                full, empty, push, pop;
    logic                head_zero, credit_free, credit_ret, issue, drop;
    logic                div_start_q, dz_pulse_q;
    logic [SIZE-1:0]     div_num_q, div_den_q;
    logic [IW-1:0]       inflight_q, inflight_d;
    logic [DZ_CNT_W-1:0] dz_count_q, dz_count_d;

    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;

    always_comb begin
        wr_pair     = '0;
        wr_pair.num = operand_t'(in_num);
        wr_pair.den = operand_t'(in_den);
    end

    divisor_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (wr_pair),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    // One head action per cycle: drop a zero divisor, or issue when a credit is free.
    assign head_zero   = (head.den == '0);
    assign credit_free = (inflight_q < IW'(MAX_INFLIGHT));
    assign drop        = !empty && head_zero;
    assign issue       = !empty && !head_zero && credit_free;
    assign pop         = drop || issue;

    // A returned credit with nothing outstanding is ignored.
    assign credit_ret = res_taken && (inflight_q != '0);

    always_comb begin
        inflight_d = inflight_q;
        if (issue && !credit_ret) begin
            inflight_d = inflight_q + IW'(1);
        end else if (!issue && credit_ret) begin
            inflight_d = inflight_q - IW'(1);
        end
    end

    always_comb begin
        dz_count_d = dz_count_q;
        if (drop && (dz_count_q != '1)) begin
            dz_count_d = dz_count_q + DZ_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_start_q <= 1'b0;
            div_num_q   <= '0;
            div_den_q   <= '0;
            dz_pulse_q  <= 1'b0;
            dz_count_q  <= '0;
            inflight_q  <= '0;
        end else begin
            div_start_q <= issue;
            dz_pulse_q  <= drop;
            dz_count_q  <= dz_count_d;
            inflight_q  <= inflight_d;
            if (issue) begin
                div_num_q <= head.num[SIZE-1:0];
                div_den_q <= head.den[SIZE-1:0];
            end
        end
    end

    assign div_start = div_start_q;
    assign div_num   = div_num_q;
    assign div_den   = div_den_q;
    assign dz_pulse  = dz_pulse_q;
    assign dz_count  = dz_count_q;
    assign inflight  = inflight_q;

endmodule
